// File: rtl/proc_pkg.sv
// Shared types for the write-back stage and register file.
// Stage-register bundle carried from capture to commit.
package proc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 8;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        word_t     data;
    } wb_stage_t;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: bypass from the pending write, else the array.
// With WB_REG0_ZERO_EN defined, address 0 always reads as zero.
module regfile_read_port
    import proc_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] arr_data_i,
    input  logic              pend_v_i,
    input  logic [ADDR_W-1:0] pend_rd_i,
    input  logic [DATA_W-1:0] pend_data_i,
    output logic [DATA_W-1:0] data_o
);

    logic hit;

    assign hit = pend_v_i && (addr_i == pend_rd_i);

    // Select pending data on an address hit, otherwise the stored word.
    always_comb begin
        data_o = arr_data_i;
        if (hit) begin
            data_o = pend_data_i;
        end
`ifdef WB_REG0_ZERO_EN
        if (addr_i == '0) begin
            data_o = '0;
        end
`endif
    end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back pipeline register, 8-entry register array and retire counter.
// Optional WB_REG0_ZERO_EN makes register 0 read-only zero.
module writeback_regfile
    import proc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] r1_data,
    output logic [DATA_W-1:0] r2_data,
    output logic              wb_pending,
    output logic [CNT_W-1:0]  retire_cnt
);

    wb_stage_t        pend_q, pend_d;
    word_t            regs_q [NREG];
    logic [CNT_W-1:0] cnt_q;
    logic             commit_en;

`ifdef WB_REG0_ZERO_EN
    assign commit_en = pend_q.valid && (pend_q.rd != '0);
`else
    assign commit_en = pend_q.valid;
`endif

    // Next stage contents: capture a valid result, otherwise hold rd/data.
    always_comb begin
        pend_d       = pend_q;
        pend_d.valid = 1'b0;
        if (wb_valid) begin
            pend_d.valid = 1'b1;
            pend_d.rd    = wb_rd;
            pend_d.data  = wb_data;
        end
    end

    // Stage register, array commit and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            if (commit_en) begin
                regs_q[pend_q.rd] <= pend_q.data;
            end
            if (pend_q.valid) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    regfile_read_port u_rp1 (
        .addr_i      (rs1_addr),
        .arr_data_i  (regs_q[rs1_addr]),
        .pend_v_i    (pend_q.valid),
        .pend_rd_i   (pend_q.rd),
        .pend_data_i (pend_q.data),
        .data_o      (r1_data)
    );

    regfile_read_port u_rp2 (
        .addr_i      (rs2_addr),
        .arr_data_i  (regs_q[rs2_addr]),
        .pend_v_i    (pend_q.valid),
        .pend_rd_i   (pend_q.rd),
        .pend_data_i (pend_q.data),
        .data_o      (r2_data)
    );

    assign wb_pending = pend_q.valid;
    assign retire_cnt = cnt_q;

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back stage and 8-entry register file directly downstream of the execute unit.
- Captures the execute result (16-bit data plus 3-bit destination) into a write-back pipeline register, then commits it to the register array on the next clock.
- Provides two combinational read ports, with bypass from the pending write, that feed r1_data/r2_data back to the execute unit.

Parameters:
- DATA_W, 16, register and result width
- ADDR_W, 3, register address width
- NREG, 8, number of registers; must equal 2**ADDR_W
- CNT_W, 16, width of the retired-write counter

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset, sampled on rising clk
- wb_valid  input  1  execute result valid this cycle
- wb_data  input  DATA_W  result from execute (its data_out)
- wb_rd  input  ADDR_W  destination register from execute (its rd_out)
- rs1_addr  input  ADDR_W  read port 1 address
- rs2_addr  input  ADDR_W  read port 2 address
- r1_data  output  DATA_W  read port 1 data, to execute r1_data
- r2_data  output  DATA_W  read port 2 data, to execute r2_data
- wb_pending  output  1  write-back register holds an uncommitted write
- retire_cnt  output  CNT_W  number of writes committed to the array

Behaviour:
- State:
  - regs[0..NREG-1] (DATA_W each)
  - stage register: pend_v, pend_rd, pend_data
  - retire_cnt
- Reset, at the rising edge with reset=1:
  - all regs = 0, pend_v = 0, pend_rd = 0, pend_data = 0, retire_cnt = 0
  - Consequences: r1_data = r2_data = 0 and wb_pending = 0 from the following cycle.
  - reset has priority over every other event. A pending write is discarded; it is never committed and never counted.
- Capture, edge N, when wb_valid=1:
  - pend_v <= 1, pend_rd <= wb_rd, pend_data <= wb_data
  - When wb_valid=0: pend_v <= 0 and pend_rd/pend_data hold.
- Commit, same edge N, when pend_v=1 before the edge:
  - regs[pend_rd] <= pend_data
  - retire_cnt <= retire_cnt + 1, wrapping from 2**CNT_W-1 to 0
- Latency:
  - Result visible on the read ports from cycle N+1 via bypass.
  - Result present in the array from cycle N+2.
  - No stalls; one result accepted every cycle.
- Back-to-back writes to the same rd (edges N, N+1):
  - At N+1 the older value commits to the array while the newer value loads into the stage.
  - Reads return the newer value from cycle N+2 onward.
  - The final array value is the newer one.
- Read ports (combinational; rs1 and rs2 are independent and identical):
  - if pend_v and rsX_addr == pend_rd: return pend_data
  - else: return regs[rsX_addr]
  - Both ports may read the same address.
  - No bypass from the live wb_* inputs; this prevents a combinational loop through execute.
- wb_pending = pend_v.
- X/illegal: wb_rd and wb_data are ignored whenever wb_valid=0.

Optional Feature:
- Macro: WB_REG0_ZERO_EN
- Defined:
  - Register 0 is hardwired to zero; reads of address 0 always return 0, with no bypass.
  - A write with wb_rd=0 is still captured (pend_v=1) and still counted in retire_cnt, but never modifies regs[0].
- Undefined: register 0 is an ordinary writable register.

Decomposition:
- Shared package `proc_pkg`:
  - DATA_W=16, ADDR_W=3, NREG=8
  - typedefs reg_addr_t (3 bits) and word_t (16 bits)
  - the stage-register struct {valid, rd, data}
- One natural sub-module, `regfile_read_port`: the address-compare-and-bypass mux, instantiated twice.
- Array, stage register and counter stay in the top module.

Test Plan:
- Reset: write r3=0x1234, assert reset for 1 cycle -> all reads 0, retire_cnt=0, wb_pending=0.
- Single write: wb_valid=1, wb_rd=5, wb_data=0xBEEF at edge N, rs1_addr=5 -> r1_data=0xBEEF in cycle N+1 (bypass) and N+2 (array); retire_cnt=1 after edge N+1.
- Back-to-back same rd: rd=2 gets 0x0011 then 0x0022 on consecutive edges -> rs1=rs2=2 reads 0x0011 for one cycle, then 0x0022 indefinitely; retire_cnt=2.
- Dual-port independence: regs r1=0x000A, r6=0x00F0 and pending write r6=0x0F00 -> rs1=1 gives 0x000A, rs2=6 gives 0x0F00.
- Reset mid-flight: capture r4=0x5555, reset on the next edge -> r4 reads 0, retire_cnt=0.
- WB_REG0_ZERO_EN defined: write r0=0xFFFF -> r0 reads 0 in every cycle, retire_cnt increments by 1. Undefined: r0 reads 0xFFFF from cycle N+1.
